// File: rtl/inc_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// inc_share_arbiter_pkg
// Purpose : Shared types and helpers for the shared-incrementer arbiter.
//           Holds the FSM state encoding (IDLE = result register empty,
//           HOLD = result register full) and a small modulo helper used by
//           the round-robin pointer arithmetic.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package inc_share_arbiter_pkg;

    // Result-register occupancy FSM.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Reduce v into [0, n) for 0 <= v < 2*n; the round-robin arithmetic
    // never exceeds that range, so a single conditional subtract suffices.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage : inc_share_arbiter_pkg

// File: rtl/inc_share_arbiter_inc.sv
// -----------------------------------------------------------------------------
// inc_share_arbiter_inc
// Purpose : The shared combinational incrementer. Exactly one instance exists
//           in the arbiter; every requester's operand is routed through it.
// Ports   :
//   i_operand  in   WIDTH  value to increment
//   o_result   out  WIDTH  i_operand + 1, modulo 2^WIDTH
// -----------------------------------------------------------------------------
module inc_share_arbiter_inc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_result
);

    // Carry out of the MSB is intentionally dropped: all-ones wraps to zero.
    assign o_result = i_operand + WIDTH'(1);

endmodule : inc_share_arbiter_inc

// File: rtl/inc_share_arbiter.sv
// -----------------------------------------------------------------------------
// inc_share_arbiter
// Purpose : Shares one combinational incrementer between NREQ requesters.
//           A round-robin pick selects one pending operand per cycle, the
//           operand is incremented by the single shared incrementer, and the
//           result is registered together with the requester index. The
//           result side is a valid/ready interface.
// Parameters:
//   WIDTH  operand/result width in bits
//   NREQ   number of requesters (2..8)
//   IDW    requester index width; must equal $clog2(NREQ)
// Ports   :
//   Clk         in   1           rising-edge clock
//   Rst         in   1           asynchronous, active-high reset
//   req_valid   in   NREQ        bit i: requester i has an operand pending
//   req_data    in   NREQ*WIDTH  operand i at [i*WIDTH +: WIDTH]
//   req_ready   out  NREQ        one-hot accept pulse, same cycle as the pick
//   resp_valid  out  1           result register holds a valid result
//   resp_ready  in   1           consumer takes the result this cycle
//   resp_data   out  WIDTH       operand + 1, modulo 2^WIDTH
//   resp_id     out  IDW         requester that produced resp_data
//   resp_wrap   out  1           operand was all ones (result wrapped to 0)
// -----------------------------------------------------------------------------
module inc_share_arbiter
    import inc_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_wrap
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_e           r_state;
    state_e           w_state_next;
    logic [IDW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0] r_resp_data;
    logic [IDW-1:0]   r_resp_id;
    logic             r_resp_wrap;

    logic [WIDTH-1:0] w_req_op [NREQ];
    logic             w_grant_found;
    logic [IDW-1:0]   w_grant_idx;
    logic [IDW-1:0]   w_rr_next;
    logic             w_can_accept;
    logic             w_accept;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_inc_out;
    logic             w_operand_ones;

    // -------------------------------------------------------------------------
    // Operand unpacking: flat bus -> one slot per requester
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_req_op[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid requester scanning from r_rr_ptr upward,
    // wrapping at NREQ. The scan is pure combinational priority logic; the
    // pointer only moves when a grant is actually taken.
    // -------------------------------------------------------------------------
    always_comb begin : p_rr_pick
        logic [IDW-1:0] v_idx;
        // NOTE: every variable written here gets a default first; a path
        // that leaves one unassigned would infer a latch.
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = IDW'(rr_wrap(int'(r_rr_ptr) + k, NREQ));
            if (!w_grant_found && req_valid[v_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_idx;
            end
        end
    end

    // Pointer moves one past the winner so the winner has lowest priority next.
    assign w_rr_next = IDW'(rr_wrap(int'(w_grant_idx) + 1, NREQ));

    // -------------------------------------------------------------------------
    // Operand mux and the single shared incrementer
    // -------------------------------------------------------------------------
    assign w_operand      = w_req_op[w_grant_idx];
    assign w_operand_ones = &w_operand;

    inc_share_arbiter_inc #(
        .WIDTH (WIDTH)
    ) u_inc (
        .i_operand (w_operand),
        .o_result  (w_inc_out)
    );

    // -------------------------------------------------------------------------
    // FSM process 1: state register plus the result and pointer registers,
    // all loaded by the same accept event.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin : p_regs
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_resp_data <= '0;
            r_resp_id   <= '0;
            r_resp_wrap <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_rr_ptr    <= w_rr_next;
                r_resp_data <= w_inc_out;
                r_resp_id   <= w_grant_idx;
                r_resp_wrap <= w_operand_ones;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    //   IDLE: any accept fills the register -> HOLD.
    //   HOLD: consumer draining with a refill stays in HOLD; draining without
    //         a refill empties the register -> IDLE; no drain stalls.
    // -------------------------------------------------------------------------
    always_comb begin : p_next_state
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                 w_state_next = ST_HOLD;
            ST_HOLD: if (resp_ready && !w_accept)  w_state_next = ST_IDLE;
            default:                               w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs
    // A new operand can be taken whenever the result register is empty or is
    // being drained this cycle. Rst gates the accept so no requester sees a
    // ready pulse while the block is held in reset.
    // -------------------------------------------------------------------------
    always_comb begin : p_outputs
        w_can_accept = (r_state == ST_IDLE) || resp_ready;
        w_accept     = w_can_accept && w_grant_found && !Rst;
        req_ready    = '0;
        if (w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign resp_valid = (r_state == ST_HOLD);
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign resp_wrap  = r_resp_wrap;

endmodule : inc_share_arbiter

// File: tb/tb_inc_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inc_share_arbiter
// Purpose : Directed-vector bench for inc_share_arbiter (WIDTH=16, NREQ=4).
//           The stimulus process drives one vector per cycle, checks the
//           same-cycle req_ready grant against a hand-computed value and
//           pushes the expected response; a separate monitor compares every
//           presented response against the queue head and pops it on a
//           completed handshake.
// -----------------------------------------------------------------------------
module tb_inc_share_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
        logic             wrap;
    } resp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic [IDW-1:0]        resp_id;
    logic                  resp_wrap;

    logic [WIDTH-1:0] d [NREQ];
    resp_t            exp_q [$];
    int               n_checks;
    int               n_errors;

    inc_share_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_wrap  (resp_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus. Called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [NREQ-1:0] v, input logic rr,
                        input logic [NREQ-1:0] exp_rdy, input string name);
        resp_t e;
        req_valid  = v;
        resp_ready = rr;
        req_data   = {d[3], d[2], d[1], d[0]};
        @(negedge clk);
        check({name, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i]) begin
                e.data = d[i] + 16'h0001;
                e.id   = IDW'(i);
                e.wrap = (d[i] == 16'hFFFF);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the queue head; during a
    // stall the same head is compared again, so held outputs must not move.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'(0));
            end else begin
                check("resp_data_id_wrap", 32'({resp_data, resp_id, resp_wrap}), 32'(exp_q[0]));
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) d[i] = '0;
        req_data   = '0;

        #1;
        check("por_resp_valid", 32'(resp_valid), 32'(0));
        check("por_resp_all",   32'({resp_data, resp_id, resp_wrap}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester 2: 00AB -> 00AC, id 2, no wrap (ptr 0 -> 3).
        d[2] = 16'h00AB;
        step(4'b0100, 1'b1, 4'b0100, "single_grant");
        step(4'b0000, 1'b1, 4'b0000, "single_drain");

        // Wrap-around on requester 0 (ptr 3 scans 3,0 -> grant 0, ptr -> 1).
        d[0] = 16'hFFFF;
        step(4'b0001, 1'b1, 4'b0001, "wrap_grant");
        step(4'b0000, 1'b1, 4'b0000, "wrap_drain");

        // Pointer skip: ptr 1, valid 1001 -> grant 3, then grant 0 (ptr -> 1).
        d[0] = 16'h0010;
        d[3] = 16'h1234;
        step(4'b1001, 1'b1, 4'b1000, "skip_grant3");
        step(4'b1001, 1'b1, 4'b0001, "skip_grant0");
        step(4'b0000, 1'b1, 4'b0000, "skip_drain");

        // Backpressure: grant 1, stall three cycles, then grant 2 on release.
        d[1] = 16'h7FFF;
        d[2] = 16'h0100;
        step(4'b0110, 1'b1, 4'b0010, "bp_grant1");
        step(4'b0110, 1'b0, 4'b0000, "bp_stall1");
        step(4'b0110, 1'b0, 4'b0000, "bp_stall2");
        step(4'b0110, 1'b0, 4'b0000, "bp_stall3");
        step(4'b0110, 1'b1, 4'b0100, "bp_release");
        step(4'b0000, 1'b1, 4'b0000, "bp_drain");

        // Reset mid-run with a held result: IDLE accept (ptr 3 -> grant 0).
        d[0] = 16'h0005;
        step(4'b0001, 1'b0, 4'b0001, "rst_fill");
        step(4'b1111, 1'b0, 4'b0000, "rst_hold");
        resp_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_resp_all",   32'({resp_data, resp_id, resp_wrap}), 32'(0));
        check("rst_req_ready",  32'(req_ready), 32'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness from a fresh pointer: grants 0,1,2,3,0 back to back.
        d[0] = 16'h1000;
        d[1] = 16'h2001;
        d[2] = 16'h3002;
        d[3] = 16'h4003;
        step(4'b1111, 1'b1, 4'b0001, "fair_g0");
        step(4'b1111, 1'b1, 4'b0010, "fair_g1");
        step(4'b1111, 1'b1, 4'b0100, "fair_g2");
        step(4'b1111, 1'b1, 4'b1000, "fair_g3");
        step(4'b1111, 1'b1, 4'b0001, "fair_g0b");
        step(4'b0000, 1'b1, 4'b0000, "fair_drain");

        // Wrap on the highest index (ptr 1 scans 1,2,3 -> grant 3).
        d[3] = 16'hFFFF;
        step(4'b1000, 1'b1, 4'b1000, "wrap3_grant");
        step(4'b0000, 1'b1, 4'b0000, "wrap3_drain");
        step(4'b0000, 1'b0, 4'b0000, "idle");

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        check("final_resp_valid", 32'(resp_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_inc_share_arbiter
